sprite_blitter: RTL and testbench

//  Reads one sprite from a sprite_ram_module-style ROM (1-cycle read latency) and writes it to the VGA adapter.
//  It sweeps the sprite raster, aligns the returned colour with the address that produced it, and offsets each

---
 rtl/sprite_blitter.sv | 166 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sweeps a sprite ROM and writes offset, clipped pixels to the VGA adapter port.
// Optional colour-key transparency: SPRITE_BLITTER_TRANSPARENCY_EN.
module sprite_blitter #(
  parameter int         SPRITE_W          = 10,
  parameter int         SPRITE_H          = 6,
  parameter int         WIDTH_SX          = 4,
  parameter int         WIDTH_SY          = 3,
  parameter int         SCREEN_W          = 160,
  parameter int         SCREEN_H          = 120,
  parameter int         WIDTH_VX          = 8,
  parameter int         WIDTH_VY          = 7,
  parameter logic [2:0] TRANSPARENT_COLOR = 3'b000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [WIDTH_VX-1:0] pos_x,
  input  logic [WIDTH_VY-1:0] pos_y,
  output logic                busy,
  output logic                done,
  output logic [WIDTH_SX-1:0] rom_x,
  output logic [WIDTH_SY-1:0] rom_y,
  input  logic [2:0]          rom_color,
  output logic [WIDTH_VX-1:0] vga_x,
  output logic [WIDTH_VY-1:0] vga_y,
  output logic [2:0]          vga_colour,
  output logic                vga_plot
);

  localparam logic [WIDTH_SX-1:0] SX_LAST = WIDTH_SX'(SPRITE_W - 1);
  localparam logic [WIDTH_SY-1:0] SY_LAST = WIDTH_SY'(SPRITE_H - 1);
  localparam logic [WIDTH_VX:0]   SCR_W   = (WIDTH_VX+1)'(SCREEN_W);
  localparam logic [WIDTH_VY:0]   SCR_H   = (WIDTH_VY+1)'(SCREEN_H);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH_SX-1:0] sx_q, sx_d;
  logic [WIDTH_SY-1:0] sy_q, sy_d;
  logic                drain_q, drain_d;
  logic [WIDTH_VX-1:0] px_q, px_d;
  logic [WIDTH_VY-1:0] py_q, py_d;

  logic                s1_valid_q;
  logic [WIDTH_SX-1:0] s1_sx_q;
  logic [WIDTH_SY-1:0] s1_sy_q;

  logic [WIDTH_VX-1:0] vx_q;
  logic [WIDTH_VY-1:0] vy_q;
  logic [2:0]          vc_q;
  logic                plot_q, plot_d;

  logic                last_addr;
  logic [WIDTH_VX:0]   sum_x;
  logic [WIDTH_VY:0]   sum_y;
  logic                clip;
  logic                transparent;

  assign last_addr = (sx_q == SX_LAST) && (sy_q == SY_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      drain_q <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      drain_q <= drain_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    drain_d = drain_q;
    px_d    = px_q;
    py_d    = py_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          px_d    = pos_x;
          py_d    = pos_y;
          sx_d    = '0;
          sy_d    = '0;
        end
      end
      S_FETCH: begin
        if (last_addr) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else if (sx_q == SX_LAST) begin
          sx_d = '0;
          sy_d = sy_q + 1'b1;
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Two cycles: drain_q marks the second one.
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1 delays the address by one cycle so it lines up with rom_color.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_sx_q    <= '0;
      s1_sy_q    <= '0;
    end else begin
      s1_valid_q <= (state_q == S_FETCH);
      s1_sx_q    <= sx_q;
      s1_sy_q    <= sy_q;
    end
  end

  assign sum_x       = (WIDTH_VX+1)'(px_q) + (WIDTH_VX+1)'(s1_sx_q);
  assign sum_y       = (WIDTH_VY+1)'(py_q) + (WIDTH_VY+1)'(s1_sy_q);
  assign clip        = (sum_x >= SCR_W) || (sum_y >= SCR_H);
  assign transparent = TRANSP_EN && (rom_color == TRANSPARENT_COLOR);
  assign plot_d      = s1_valid_q && !clip && !transparent;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vx_q   <= '0;
      vy_q   <= '0;
      vc_q   <= '0;
      plot_q <= 1'b0;
    end else begin
      plot_q <= plot_d;
      if (plot_d) begin
        vx_q <= sum_x[WIDTH_VX-1:0];
        vy_q <= sum_y[WIDTH_VY-1:0];
        vc_q <= rom_color;
      end
    end
  end

  assign busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign rom_x      = sx_q;
  assign rom_y      = sy_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;
  assign vga_plot   = plot_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard bench for sprite_blitter with a pixel-list reference model.
module tb_sprite_blitter;
  localparam int W = 10;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       busy, done;
  logic [3:0] rom_x;
  logic [2:0] rom_y;
  logic [2:0] rom_color;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  logic       start1;
  logic       busy1, done1;
  logic [0:0] rx1, ry1;
  logic [2:0] rom_color1;
  logic [7:0] vx1, pos_x1;
  logic [6:0] vy1, pos_y1;
  logic [2:0] vc1;
  logic       plot1;

  sprite_blitter u_dut (
    .clk(clk), .resetn(resetn), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .busy(busy), .done(done), .rom_x(rom_x), .rom_y(rom_y), .rom_color(rom_color),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  sprite_blitter #(.SPRITE_W(1), .SPRITE_H(1), .WIDTH_SX(1), .WIDTH_SY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .pos_x(pos_x1), .pos_y(pos_y1),
    .busy(busy1), .done(done1), .rom_x(rx1), .rom_y(ry1), .rom_color(rom_color1),
    .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1), .vga_plot(plot1)
  );

  typedef struct { int cyc; int x; int y; int c; } exp_t;
  exp_t sb[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   cur_acc = 0;
  int   next_ok = 0;
  bit   active = 0;
  logic [2:0] rom_mem [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    int idx;
    idx = int'(rom_y) * W + int'(rom_x);
    rom_color <= (idx < N) ? rom_mem[idx] : 3'b000;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: timing of busy/done/address plus scoreboard of plotted pixels.
  always @(negedge clk) begin
    if (resetn) begin
      bit exp_busy, exp_done;
      exp_t e;
      exp_busy = active && cyc >= cur_acc && cyc <= cur_acc + N + 1;
      exp_done = active && cyc == cur_acc + N + 2;
      tests++;
      if (busy !== exp_busy || done !== exp_done) begin
        fails++;
        $display("FAIL busy_done cyc=%0d got busy=%b done=%b want busy=%b done=%b",
                 cyc, busy, done, exp_busy, exp_done);
      end
      if (exp_busy) begin
        int k;
        k = cyc - cur_acc;
        if (k > N - 1) k = N - 1;
        tests++;
        if (int'(rom_x) != k % W || int'(rom_y) != k / W) begin
          fails++;
          $display("FAIL rom_addr cyc=%0d got (%0d,%0d) want (%0d,%0d)",
                   cyc, rom_x, rom_y, k % W, k / W);
        end
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL missed_plot cyc=%0d got none want (%0d,%0d,c=%0d)", e.cyc, e.x, e.y, e.c);
      end
      if (vga_plot) begin
        tests++;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          fails++;
          $display("FAIL extra_plot cyc=%0d got (%0d,%0d,c=%0d) want no plot", cyc, vga_x, vga_y, vga_colour);
        end else begin
          e = sb.pop_front();
          if (int'(vga_x) != e.x || int'(vga_y) != e.y || int'(vga_colour) != e.c) begin
            fails++;
            $display("FAIL plot_data cyc=%0d got (%0d,%0d,c=%0d) want (%0d,%0d,c=%0d)",
                     cyc, vga_x, vga_y, vga_colour, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  task automatic load_rom(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       rom_mem[i] = 3'((i % W + i / W) % 8);
        1:       rom_mem[i] = 3'($urandom % 8);
        default: rom_mem[i] = (i / W == 0) ? 3'b000 : 3'($urandom % 8);
      endcase
    end
  endtask

  // Reference model: every sprite pixel in raster order, offset, clipped, keyed.
  task automatic do_blit(input int px, input int py, input int mode);
    exp_t e;
    int   acc;
    while (cyc < next_ok) begin @(posedge clk); #1; end
    load_rom(mode);
    acc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      e.cyc = acc + i + 2;
      e.x   = px + i % W;
      e.y   = py + i / W;
      e.c   = int'(rom_mem[i]);
      if (e.x < 160 && e.y < 120) begin
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
        if (e.c != 0) sb.push_back(e);
`else
        sb.push_back(e);
`endif
      end
    end
    pos_x = 8'(px);
    pos_y = 7'(py);
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    cur_acc = acc;
    active  = 1'b1;
    next_ok = acc + N + 3;
  endtask

  // While busy/DONE: mode 0 quiet, 1 random start/pos noise, 2 start held high.
  task automatic ride(input int mode);
    while (cyc < next_ok) begin
      if (mode == 1) start = 1'($urandom % 2);
      if (mode == 2) start = 1'b1;
      if (mode != 0) begin
        pos_x = 8'($urandom);
        pos_y = 7'($urandom);
      end
      @(posedge clk); #1;
    end
    if (mode == 1) start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || rom_x !== 4'd0 || rom_y !== 3'd0 ||
        vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0 || vga_plot !== 1'b0) begin
      fails++;
      $display("FAIL %s got busy=%b done=%b rom=(%0d,%0d) vga=(%0d,%0d,%0d) plot=%b want all 0",
               tag, busy, done, rom_x, rom_y, vga_x, vga_y, vga_colour, vga_plot);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; pos_x = '0; pos_y = '0;
    start1 = 1'b0; pos_x1 = '0; pos_y1 = '0; rom_color1 = 3'b101;
    load_rom(0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    resetn = 1'b1;
    @(posedge clk); #1;
    next_ok = cyc;

    do_blit(20, 30, 0);   ride(0);
    do_blit(155, 117, 1); ride(1);

    do_blit(40, 50, 1);
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    sb.delete();
    active = 1'b0;
    #1;
    check_outputs_zero("reset_mid_fetch");
    @(posedge clk); #1;
    resetn  = 1'b1;
    next_ok = cyc;

    do_blit(20, 30, 2); ride(0);

    for (int b = 0; b < 3; b++) begin
      do_blit(int'($urandom_range(0, 170)), int'($urandom_range(0, 127)), 1);
      ride(2);
    end
    start = 1'b0;

    do_blit(159, 119, 1); ride(1);
    do_blit(150, 114, 0); ride(0);
    do_blit(0, 0, 1);     ride(1);
    for (int r = 0; r < 4; r++) begin
      do_blit(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), int'($urandom_range(0, 2)));
      ride(int'($urandom_range(0, 1)));
    end

    // 1x1 sprite instance: plot in cycle 3, done in cycle 4.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (plot1 !== (k == 2) || done1 !== (k == 3) || busy1 !== (k <= 2)) begin
        fails++;
        $display("FAIL one_pixel_timing k=%0d got plot=%b done=%b busy=%b want plot=%b done=%b busy=%b",
                 k, plot1, done1, busy1, (k == 2), (k == 3), (k <= 2));
      end
      if (k == 2) begin
        tests++;
        if (vx1 !== 8'd0 || vy1 !== 7'd0 || vc1 !== 3'b101) begin
          fails++;
          $display("FAIL one_pixel_data got (%0d,%0d,c=%0d) want (0,0,c=5)", vx1, vy1, vc1);
        end
      end
      @(posedge clk); #1;
    end

    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
